// File: rtl/exe_div_ctrl.sv
// Iterative radix-2 restoring divider sequencer for the execute stage (RV32M DIV/DIVU/REM/REMU).
// Stalls the front of the pipe while iterating and holds a registered result until the E->M advance.
module exe_div_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            div_req,
    input  logic [1:0]      div_op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            kill,
    input  logic            adv,
    output logic            div_stall,
    output logic            div_valid,
    output logic [XLEN-1:0] div_result,
    output logic            div_busy
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  dvs_q, dvs_d;
    logic [XLEN-1:0]  res_q, res_d;
    logic [1:0]       op_q, op_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;

    logic             stall_c, valid_c;

    function automatic logic [XLEN-1:0] finalize(input logic [1:0] op,
                                                 input logic [XLEN-1:0] q,
                                                 input logic [XLEN-1:0] r,
                                                 input logic qn,
                                                 input logic rn);
        logic [XLEN-1:0] v;
        logic            n;
        v = op[1] ? r : q;
        n = op[1] ? rn : qn;
        return n ? -v : v;
    endfunction

    // Request decode: magnitudes, sign flags and the two no-iteration cases.
    logic            is_signed, s1, s2, div0, ovf;
    logic [XLEN-1:0] abs1, abs2, spec_res;

    assign is_signed = ~div_op[0];
    assign s1        = is_signed & rs1_data[XLEN-1];
    assign s2        = is_signed & rs2_data[XLEN-1];
    assign abs1      = s1 ? -rs1_data : rs1_data;
    assign abs2      = s2 ? -rs2_data : rs2_data;
    assign div0      = (rs2_data == '0);
    assign ovf       = is_signed & (rs1_data == MIN_NEG) & (rs2_data == '1);
    assign spec_res  = div_op[1] ? (div0 ? rs1_data : '0)
                                 : (div0 ? '1 : MIN_NEG);

    // One restoring step; the extra top bit keeps the shifted partial remainder exact.
    logic [XLEN:0]   rem_sh, trial;
    logic            ge;
    logic [XLEN-1:0] rem_nx, quo_nx;

    assign rem_sh = {rem_q, quo_q[XLEN-1]};
    assign trial  = rem_sh - {1'b0, dvs_q};
    assign ge     = ~trial[XLEN];
    assign rem_nx = ge ? trial[XLEN-1:0] : rem_sh[XLEN-1:0];
    assign quo_nx = {quo_q[XLEN-2:0], ge};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        res_d   = res_q;
        op_d    = op_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        stall_c = 1'b0;
        valid_c = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (div_req && !kill) begin
                    stall_c = 1'b1;
                    op_d    = div_op;
                    qneg_d  = s1 ^ s2;
                    rneg_d  = s1;
                    rem_d   = '0;
                    quo_d   = abs1;
                    dvs_d   = abs2;
                    if (div0 || ovf) begin
                        res_d   = spec_res;
                        state_d = DONE;
                    end else begin
                        cnt_d   = CNT_W'(XLEN);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                stall_c = 1'b1;
                rem_d   = rem_nx;
                quo_d   = quo_nx;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    res_d   = finalize(op_q, quo_nx, rem_nx, qneg_q, rneg_q);
                    state_d = DONE;
                end
            end
            DONE: begin
                valid_c = 1'b1;
                if (adv) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A flush wins over everything: release the pipe and drop the op.
        if (kill) begin
            state_d = IDLE;
            stall_c = 1'b0;
            valid_c = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            res_q   <= '0;
            op_q    <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            res_q   <= res_d;
            op_q    <= op_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end

    // The request-path stall is combinational, so it must also be gated while reset is held.
    assign div_stall  = stall_c & rst;
    assign div_valid  = valid_c & rst;
    assign div_result = div_valid ? res_q : '0;
    assign div_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_exe_div_ctrl.sv
// Randomized and directed bench for exe_div_ctrl against an arithmetic reference model.
module tb_exe_div_ctrl;

    localparam int XLEN = 32;
    localparam int LAT  = XLEN + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            div_req;
    logic [1:0]      div_op;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            kill;
    logic            adv;
    logic            div_stall;
    logic            div_valid;
    logic [XLEN-1:0] div_result;
    logic            div_busy;

    int n_vec = 0;
    int n_err = 0;

    exe_div_ctrl #(.XLEN(XLEN), .CNT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .div_req   (div_req),
        .div_op    (div_op),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .kill      (kill),
        .adv       (adv),
        .div_stall (div_stall),
        .div_valid (div_valid),
        .div_result(div_result),
        .div_busy  (div_busy)
    );

    always #5 clk = ~clk;

    // RV32M semantics from plain integer arithmetic.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b, output bit special);
        int sa;
        int sb;
        special = 1'b1;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'd0 : 32'h8000_0000;
        special = 1'b0;
        if (!op[0]) begin
            sa = a;
            sb = b;
            return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return op[1] ? (a % b) : (a / b);
    endfunction

    // Issues one request with adv=1, scrambles the operand inputs after acceptance,
    // and reports the cycle on which div_valid appeared (-1 on timeout).
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res, output int stalls);
        bit got;
        got    = 1'b0;
        lat    = -1;
        res    = '0;
        stalls = 0;
        @(posedge clk); #1;
        div_op = op; rs1_data = a; rs2_data = b; div_req = 1'b1; adv = 1'b1;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (div_stall) stalls++;
            if (div_valid) begin
                got = 1'b1;
                lat = c;
                res = div_result;
            end else begin
                @(posedge clk); #1;
                rs1_data = $urandom;
                rs2_data = $urandom;
            end
        end
        @(posedge clk); #1;
        div_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; div_req = 1'b1; div_op = 2'b00; rs1_data = 32'd50; rs2_data = 32'd5;
        kill = 1'b0; adv = 1'b1;
        #12;
        n_vec++;
        if ({div_stall, div_valid, div_busy, div_result} !== 35'd0) begin
            n_err++;
            $display("FAIL reset_hold: outputs=%h required 0", {div_stall, div_valid, div_busy, div_result});
        end
        div_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({div_stall, div_valid, div_busy, div_result} !== 35'd0) begin
            n_err++;
            $display("FAIL reset_release: outputs=%h required 0", {div_stall, div_valid, div_busy, div_result});
        end
    endtask

    task automatic test_directed();
        logic [1:0]  ops[10]  = '{2'b00, 2'b10, 2'b00, 2'b10, 2'b01, 2'b00, 2'b11, 2'b00, 2'b10, 2'b11};
        logic [31:0] as[10]   = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF,
                                  32'd123, 32'd123, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs[10]   = '{32'd7, 32'd7, 32'd2, 32'd2, 32'd1,
                                  32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3};
        logic [31:0] want[10] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                  32'hFFFF_FFFF, 32'd123, 32'h8000_0000, 32'd0, 32'd2};
        int lat_w[10] = '{LAT, LAT, LAT, LAT, LAT, 1, 1, 1, 1, LAT};
        int lat, stalls;
        logic [31:0] res;
        for (int i = 0; i < 10; i++) begin
            do_op(ops[i], as[i], bs[i], lat, res, stalls);
            n_vec++;
            if (res !== want[i] || lat != lat_w[i] || stalls != lat_w[i]) begin
                n_err++;
                $display("FAIL directed[%0d]: result=%h lat=%0d stalls=%0d required result=%h lat=%0d stalls=%0d",
                         i, res, lat, stalls, want[i], lat_w[i], lat_w[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a, b, exp;
        bit          sp;
        int          lat, stalls, exp_lat;
        logic [31:0] res;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom);
            a  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'hFFFF_FFFF;
                3: b = -32'($urandom_range(1, 300));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) a = 32'h8000_0000;
            exp     = model(op, a, b, sp);
            exp_lat = sp ? 1 : LAT;
            do_op(op, a, b, lat, res, stalls);
            n_vec++;
            if (res !== exp || lat != exp_lat || stalls != exp_lat) begin
                n_err++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: result=%h lat=%0d stalls=%0d required result=%h lat=%0d",
                         i, op, a, b, res, lat, stalls, exp, exp_lat);
            end
        end
    endtask

    task automatic test_kill();
        int          lat, stalls, seen;
        logic [31:0] res;
        @(posedge clk); #1;
        div_op = 2'b00; rs1_data = 32'd1000; rs2_data = 32'd3; div_req = 1'b1; adv = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
        end
        kill = 1'b1;
        #1;
        n_vec++;
        if (div_stall !== 1'b0 || div_valid !== 1'b0 || div_busy !== 1'b1) begin
            n_err++;
            $display("FAIL kill_cycle: stall=%b valid=%b busy=%b required 0 0 1", div_stall, div_valid, div_busy);
        end
        @(posedge clk); #1;
        kill = 1'b0; div_req = 1'b0;
        @(negedge clk);
        n_vec++;
        if (div_busy !== 1'b0 || div_valid !== 1'b0) begin
            n_err++;
            $display("FAIL kill_idle: busy=%b valid=%b required 0 0", div_busy, div_valid);
        end
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (div_valid || div_busy) seen++;
        end
        n_vec++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL kill_no_valid: active cycles=%0d required 0", seen);
        end
        do_op(2'b00, 32'd20, 32'd4, lat, res, stalls);
        n_vec++;
        if (res !== 32'd5 || lat != LAT) begin
            n_err++;
            $display("FAIL kill_followup: result=%h lat=%0d required 5 lat=%0d", res, lat, LAT);
        end
    endtask

    task automatic test_back_to_back();
        bit          got;
        int          cnt;
        logic [31:0] r0;
        @(posedge clk); #1;
        div_op = 2'b00; rs1_data = 32'd1000; rs2_data = -32'd10; div_req = 1'b1; adv = 1'b0;
        got = 1'b0; cnt = 0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (div_valid) got = 1'b1;
            else begin @(posedge clk); #1; cnt++; end
        end
        r0 = div_result;
        n_vec++;
        if (!got || cnt != LAT || r0 !== -32'd100) begin
            n_err++;
            $display("FAIL hold_first: got=%b lat=%0d result=%h required lat=%0d result=%h", got, cnt, r0, LAT, -32'd100);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            div_op = 2'b01; rs1_data = 32'd48; rs2_data = 32'd6;
            @(negedge clk);
            n_vec++;
            if (div_valid !== 1'b1 || div_stall !== 1'b0 || div_result !== r0) begin
                n_err++;
                $display("FAIL hold_stable[%0d]: valid=%b stall=%b result=%h required 1 0 %h", k, div_valid, div_stall, div_result, r0);
            end
        end
        @(posedge clk); #1;
        adv = 1'b1;
        @(negedge clk);
        n_vec++;
        if (div_valid !== 1'b1 || div_result !== r0) begin
            n_err++;
            $display("FAIL hold_adv: valid=%b result=%h required 1 %h", div_valid, div_result, r0);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_vec++;
        if (div_busy !== 1'b0 || div_valid !== 1'b0 || div_stall !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_idle: busy=%b valid=%b stall=%b required 0 0 1", div_busy, div_valid, div_stall);
        end
        got = 1'b0; cnt = 0;
        for (int c = 0; c < 100 && !got; c++) begin
            if (c > 0) @(negedge clk);
            if (div_valid) got = 1'b1;
            else begin @(posedge clk); #1; cnt++; end
        end
        n_vec++;
        if (!got || cnt != LAT || div_result !== 32'd8) begin
            n_err++;
            $display("FAIL b2b_second: got=%b lat=%0d result=%h required lat=%0d result=8", got, cnt, div_result, LAT);
        end
        @(posedge clk); #1;
        div_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        int          lat, stalls;
        logic [31:0] res;
        @(posedge clk); #1;
        div_op = 2'b00; rs1_data = 32'd500; rs2_data = 32'd7; div_req = 1'b1; adv = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
        end
        #1;
        rst = 1'b0;
        #1;
        n_vec++;
        if ({div_stall, div_valid, div_busy, div_result} !== 35'd0) begin
            n_err++;
            $display("FAIL reset_mid: outputs=%h required 0", {div_stall, div_valid, div_busy, div_result});
        end
        @(posedge clk); #1;
        rst = 1'b1; div_req = 1'b0;
        do_op(2'b00, 32'd9, 32'd3, lat, res, stalls);
        n_vec++;
        if (res !== 32'd3 || lat != LAT || stalls != LAT) begin
            n_err++;
            $display("FAIL reset_followup: result=%h lat=%0d stalls=%0d required 3 lat=%0d", res, lat, stalls, LAT);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_kill();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/exe_div_ctrl.md
Name: exe_div_ctrl

Overview:
Sequencer for an iterative radix-2 integer divider attached to the execute stage. It handles RV32M DIV/DIVU/REM/REMU.
- Accepts a request from the decoded E-stage instruction.
- Freezes the pipeline through a stall output while iterating.
- Presents the result for merging into the E-stage ALU output.
- Aborts cleanly when the E-stage instruction is squashed by a mispredict flush.

Parameters:
XLEN, 32, operand/result width
CNT_W, 6, iteration counter width (must hold XLEN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
div_req  in  1  E-stage instruction is a divide/remainder op; held while div_stall=1
div_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
rs1_data  in  XLEN  forwarded dividend
rs2_data  in  XLEN  forwarded divisor
kill  in  1  E-stage flush (mispredict redirect); abort current op
adv  in  1  pipeline advances E->M this cycle
div_stall  out  1  freeze PC/IF/ID/E registers
div_valid  out  1  div_result valid for the E-stage instruction
div_result  out  XLEN  quotient or remainder
div_busy  out  1  FSM not in IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, counter=0, quotient/remainder/operand registers=0.
  - All outputs 0 while rst=0 and after release until the first request.
- States: IDLE, CALC, DONE.
- IDLE:
  - If div_req=1 and kill=0: latch the sign-corrected operands.
    - Signed ops (DIV, REM): operands as |rs1|, |rs2|; record q_neg = sign1^sign2 and r_neg = sign1.
    - Unsigned ops: operands raw, both flags 0.
  - Latch div_op.
  - If the special case applies, go to DONE; otherwise go to CALC with counter=XLEN.
  - div_stall=div_req&~kill (combinational), so the requesting cycle is already stalled.
- Special cases, resolved in IDLE with no iteration:
  - rs2=0: quotient=all ones; remainder=rs1.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF, op DIV/REM): quotient=0x80000000; remainder=0.
- CALC:
  - One restoring step per cycle: shift {rem,quo} left by 1; trial subtract the divisor.
  - If the trial result is non-negative, keep it and set quo[0]=1.
  - counter decrements; when counter reaches 1, go to DONE next edge.
  - Exactly XLEN cycles in CALC.
  - div_stall=1 throughout.
- DONE:
  - div_valid=1 and div_stall=0.
  - div_result = (op REM/REMU ? remainder : quotient), negated if the corresponding flag is set.
  - The result is registered, stable and held until adv=1, then IDLE.
  - A new div_req in the same cycle as adv is not accepted; it is sampled next cycle in IDLE.
- Latency, normal op with request first seen at cycle 0:
  - Cycle 0: IDLE, stall.
  - Cycles 1..XLEN: CALC.
  - Cycle XLEN+1: DONE.
  - div_stall is high for XLEN+1 cycles.
- Latency, special case: cycle 0 stall, cycle 1 DONE.
- kill priority:
  - kill=1 in any state forces IDLE on the next edge and suppresses div_valid in that cycle.
  - div_stall is 0 in a kill cycle so the redirect proceeds.
  - Partial results are discarded.
  - kill with div_req in IDLE: request ignored.
- Operands are latched once; changes on rs1_data/rs2_data during CALC have no effect.
- div_busy = (state != IDLE).
- The dividend -2^31 with any divisor other than -1 uses the magnitude 0x80000000 correctly; this needs an unsigned XLEN-bit datapath.

Test Plan:
- DIV rs1=100, rs2=7, adv held 1 -> div_stall high cycles 0..32; div_valid=1 at cycle 33 with result 14; REM same operands -> 2.
- DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> 0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1); DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF.
- Divide by zero: DIV 123/0 -> 0xFFFFFFFF at cycle 1; REMU 123/0 -> 123; overflow DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
- kill asserted at cycle 10 of CALC -> next cycle IDLE, div_busy=0, div_valid never asserted; a following request 20/4 -> 5 with full latency.
- DONE with adv=0 for 3 cycles -> div_valid and result held stable and div_stall=0; adv=1 -> IDLE next cycle; back-to-back second request honoured only from IDLE.
- rst driven low at CALC cycle 15 -> all outputs 0 immediately (asynchronous); after release, new request 9/3 -> 3 with normal latency.
